// File: rtl/bus_pkg.sv
// Shared encodings for the bus target: transfer-mode codes, byte strobes and FSM states.
package bus_pkg;

    // {tm1n, tm0n, ad[1:0]} address-phase codes
    localparam logic [3:0] RD_W  = 4'b1100;
    localparam logic [3:0] WR_W  = 4'b0100;
    localparam logic [3:0] WR_H0 = 4'b0101;
    localparam logic [3:0] WR_H1 = 4'b0111;
    localparam logic [3:0] WR_B0 = 4'b0000;
    localparam logic [3:0] WR_B1 = 4'b0001;
    localparam logic [3:0] WR_B2 = 4'b0010;
    localparam logic [3:0] WR_B3 = 4'b0011;

    localparam logic [3:0] WSTRB_NONE = 4'b0000;
    localparam logic [3:0] WSTRB_W    = 4'b1111;
    localparam logic [3:0] WSTRB_H0   = 4'b0011;
    localparam logic [3:0] WSTRB_H1   = 4'b1100;
    localparam logic [3:0] WSTRB_B0   = 4'b0001;
    localparam logic [3:0] WSTRB_B1   = 4'b0010;
    localparam logic [3:0] WSTRB_B2   = 4'b0100;
    localparam logic [3:0] WSTRB_B3   = 4'b1000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WDATA = 3'd1,
        REQ   = 3'd2,
        RESP  = 3'd3,
        ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/bus_tm_decode.sv
// Combinational decode of the address-phase transfer mode into direction and byte strobes.
module bus_tm_decode
    import bus_pkg::*;
(
    input  logic       i_tm1n,
    input  logic       i_tm0n,
    input  logic [1:0] i_ad_lo,
    input  logic       i_error,
    output logic       o_we,
    output logic [3:0] o_wstrb,
    output logic       o_illegal
);

    logic [3:0] w_code;

    assign w_code = {i_tm1n, i_tm0n, i_ad_lo};

    always_comb begin
        o_we      = 1'b0;
        o_wstrb   = WSTRB_NONE;
        o_illegal = 1'b0;
        case (w_code)
            RD_W:    ;
            WR_W:    begin o_we = 1'b1; o_wstrb = WSTRB_W;  end
            WR_H0:   begin o_we = 1'b1; o_wstrb = WSTRB_H0; end
            WR_H1:   begin o_we = 1'b1; o_wstrb = WSTRB_H1; end
            WR_B0:   begin o_we = 1'b1; o_wstrb = WSTRB_B0; end
            WR_B1:   begin o_we = 1'b1; o_wstrb = WSTRB_B1; end
            WR_B2:   begin o_we = 1'b1; o_wstrb = WSTRB_B2; end
            WR_B3:   begin o_we = 1'b1; o_wstrb = WSTRB_B3; end
            default: o_illegal = 1'b1;
        endcase
        if (i_error) begin
            o_illegal = 1'b1;
        end
        if (o_illegal) begin
            o_we    = 1'b0;
            o_wstrb = WSTRB_NONE;
        end
    end

endmodule

// File: rtl/bus_tgt.sv
// Bus target: decodes a multiplexed address/data cycle, performs one local access and
// returns a one-cycle active-low ready with optional error.
module bus_tgt
    import bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        bus_adrcyn,
    input  logic [31:0] bus_ad_i,
    input  logic        bus_tm1n,
    input  logic        bus_tm0n,
    input  logic        bus_error,
    output logic [31:0] bus_ad_o,
    output logic        bus_ad_oe,
    output logic        bus_rdyn,
    output logic        bus_err_o,
    output logic        loc_req,
    output logic        loc_we,
    output logic [29:0] loc_addr,
    output logic [3:0]  loc_wstrb,
    output logic [31:0] loc_wdata,
    input  logic        loc_ack,
    input  logic [31:0] loc_rdata,
    output logic        proto_err
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_ad_o, r_wdata;
    logic [29:0]   r_addr;
    logic [3:0]    r_wstrb;
    logic          r_ad_oe, r_rdyn, r_err_o, r_req, r_we, r_proto;
    logic          w_we, w_illegal, w_hit, w_accept, w_tmo;
    logic [3:0]    w_wstrb;
    logic          w_req, w_rdyn, w_err_o, w_ad_oe;

    bus_tm_decode u_dec (
        .i_tm1n    (bus_tm1n),
        .i_tm0n    (bus_tm0n),
        .i_ad_lo   (bus_ad_i[1:0]),
        .i_error   (bus_error),
        .o_we      (w_we),
        .o_wstrb   (w_wstrb),
        .o_illegal (w_illegal)
    );

    assign w_hit    = ((bus_ad_i & ADDR_MASK) == BASE_ADDR);
    assign w_accept = (r_state == IDLE) && !bus_adrcyn && w_hit;
    assign w_tmo    = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_illegal)  w_next = ERR;
                    else if (w_we)  w_next = WDATA;
                    else            w_next = REQ;
                end
            end
            WDATA:   if (bus_adrcyn) w_next = REQ;
            REQ: begin
                if (loc_ack)    w_next = RESP;
                else if (w_tmo) w_next = ERR;
            end
            RESP:    w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they register in step with it
    always_comb begin
        w_req   = (w_next == REQ);
        w_rdyn  = !((w_next == RESP) || (w_next == ERR));
        w_err_o = (w_next == ERR);
        w_ad_oe = (w_next == RESP) && !r_we;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_req   <= 1'b0;
            r_rdyn  <= 1'b1;
            r_err_o <= 1'b0;
            r_ad_oe <= 1'b0;
            r_ad_o  <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wstrb <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_proto <= 1'b0;
        end else begin
            r_req   <= w_req;
            r_rdyn  <= w_rdyn;
            r_err_o <= w_err_o;
            r_ad_oe <= w_ad_oe;
            if (w_accept) begin
                r_addr  <= bus_ad_i[31:2];
                r_we    <= w_we;
                r_wstrb <= w_wstrb;
            end
            if ((r_state == WDATA) && bus_adrcyn) begin
                r_wdata <= bus_ad_i;
            end
            if ((r_state == REQ) && loc_ack && !r_we) begin
                r_ad_o <= loc_rdata;
            end
            // Held at zero outside REQ, so every entry into REQ starts from zero
            if (r_state != REQ) begin
                r_cnt <= '0;
            end else if (!w_tmo) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_state != IDLE) && !bus_adrcyn) begin
                r_proto <= 1'b1;
            end
        end
    end

    assign bus_ad_o  = r_ad_o;
    assign bus_ad_oe = r_ad_oe;
    assign bus_rdyn  = r_rdyn;
    assign bus_err_o = r_err_o;
    assign loc_req   = r_req;
    assign loc_we    = r_we;
    assign loc_addr  = r_addr;
    assign loc_wstrb = r_wstrb;
    assign loc_wdata = r_wdata;
    assign proto_err = r_proto;

endmodule

// File: tb/tb_bus_tgt.sv
// Randomized self-checking bench for bus_tgt against a cycle-count reference model.
module tb_bus_tgt;

    localparam logic [31:0] BASE = 32'h0003_0000;
    localparam logic [31:0] MASK = 32'hFFFF_0000;
    localparam int          TMO  = 16;

    logic        clk = 1'b0;
    logic        rstn, adrcyn, tm1n, tm0n, berr_i;
    logic [31:0] ad_i, ad_o, wdata, rdata;
    logic        ad_oe, rdyn, err_o, loc_req, loc_we, loc_ack, proto_err;
    logic [29:0] loc_addr;
    logic [3:0]  wstrb;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_proto = 1'b0;

    bus_tgt #(
        .BASE_ADDR (BASE),
        .ADDR_MASK (MASK),
        .TIMEOUT   (TMO)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus_adrcyn (adrcyn),
        .bus_ad_i   (ad_i),
        .bus_tm1n   (tm1n),
        .bus_tm0n   (tm0n),
        .bus_error  (berr_i),
        .bus_ad_o   (ad_o),
        .bus_ad_oe  (ad_oe),
        .bus_rdyn   (rdyn),
        .bus_err_o  (err_o),
        .loc_req    (loc_req),
        .loc_we     (loc_we),
        .loc_addr   (loc_addr),
        .loc_wstrb  (wstrb),
        .loc_wdata  (wdata),
        .loc_ack    (loc_ack),
        .loc_rdata  (rdata),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference decode written from the transfer-mode table (tm is {tm1n, tm0n})
    task automatic ref_decode(input logic [1:0] tm, input logic [1:0] lo,
                              output logic legal, output logic we, output logic [3:0] strb);
        int ilo;
        ilo   = int'(lo);
        legal = 1'b0;
        we    = 1'b0;
        strb  = 4'b0000;
        if (tm == 2'b11 && lo == 2'b00) begin
            legal = 1'b1;
        end else if (tm == 2'b00) begin
            legal = 1'b1; we = 1'b1; strb = 4'(1 << ilo);
        end else if (tm == 2'b01 && lo != 2'b10) begin
            legal = 1'b1; we = 1'b1;
            strb  = (lo == 2'b00) ? 4'b1111 : (lo == 2'b01) ? 4'b0011 : 4'b1100;
        end
    endtask

    // One bus cycle; d = cycles the local side waits after seeing loc_req before acking,
    // poke = cycle index at which a stray address phase is injected (-1 for none).
    task automatic run_txn(input string nm, input logic [31:0] addr, input logic [1:0] tm,
                           input logic be, input logic [31:0] data, input int d,
                           input logic [31:0] rd, input int poke_in);
        logic legal, we, hit, exp_err, exp_oe;
        logic [3:0] strb;
        int req_k, rdy_k, got_req, got_rdy, poke;
        ref_decode(tm, addr[1:0], legal, we, strb);
        hit     = ((addr & MASK) == BASE);
        exp_err = 1'b0;
        poke    = poke_in;
        if (!hit) begin
            req_k = -1; rdy_k = -1;
        end else if (!legal || be) begin
            req_k = -1; rdy_k = 0; exp_err = 1'b1;
        end else begin
            req_k   = we ? 1 : 0;
            exp_err = (d >= TMO);
            rdy_k   = req_k + (exp_err ? TMO : d + 1);
        end
        exp_oe = hit && legal && !be && !we && !exp_err;
        if (!(hit && legal && !be) || poke > rdy_k || poke < 1) poke = -1;
        if (poke >= 0) exp_proto = 1'b1;

        adrcyn = 1'b0; ad_i = addr; tm1n = tm[1]; tm0n = tm[0]; berr_i = be;
        @(posedge clk); @(negedge clk);
        adrcyn = 1'b1; ad_i = data; tm1n = 1'b1; tm0n = 1'b1; berr_i = 1'b0;
        got_req = -1; got_rdy = -1;
        for (int k = 0; k < 40; k++) begin
            if (loc_req === 1'b1 && got_req < 0) begin
                got_req = k;
                check_eq({nm, " loc_addr"}, {2'b00, loc_addr}, {2'b00, addr[31:2]});
                check_eq({nm, " loc_we"}, {31'd0, loc_we}, {31'd0, we});
                check_eq({nm, " loc_wstrb"}, {28'd0, wstrb}, {28'd0, strb});
                if (we) check_eq({nm, " loc_wdata"}, wdata, data);
            end
            if (rdyn === 1'b0 && got_rdy < 0) begin
                got_rdy = k;
                check_eq({nm, " err_o"}, {31'd0, err_o}, {31'd0, exp_err});
                check_eq({nm, " req_at_rdy"}, {31'd0, loc_req}, 32'd0);
                check_eq({nm, " ad_oe"}, {31'd0, ad_oe}, {31'd0, exp_oe});
                if (exp_oe) check_eq({nm, " ad_o"}, ad_o, rd);
            end
            if (got_rdy >= 0 && k == got_rdy + 1) begin
                check_eq({nm, " rdyn_release"}, {31'd0, rdyn}, 32'd1);
                check_eq({nm, " no_b2b"}, {31'd0, loc_req}, 32'd0);
                break;
            end
            loc_ack = (loc_req === 1'b1) && (k - got_req >= d);
            rdata   = loc_ack ? rd : $urandom();
            if (k == poke) begin
                adrcyn = 1'b0; ad_i = BASE;
            end else begin
                adrcyn = 1'b1;
            end
            @(posedge clk); @(negedge clk);
        end
        loc_ack = 1'b0; adrcyn = 1'b1;
        check_eq({nm, " req_cycle"}, 32'(got_req), 32'(req_k));
        check_eq({nm, " rdy_cycle"}, 32'(got_rdy), 32'(rdy_k));
        check_eq({nm, " proto_err"}, {31'd0, proto_err}, {31'd0, exp_proto});
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  tm;
        int          r, d;
        rstn = 1'b0; adrcyn = 1'b1; ad_i = '0; tm1n = 1'b1; tm0n = 1'b1; berr_i = 1'b0;
        loc_ack = 1'b0; rdata = '0;
        repeat (2) @(negedge clk);
        check_eq("rst rdyn", {31'd0, rdyn}, 32'd1);
        check_eq("rst loc_req", {31'd0, loc_req}, 32'd0);
        check_eq("rst err_o", {31'd0, err_o}, 32'd0);
        check_eq("rst ad_oe", {31'd0, ad_oe}, 32'd0);
        check_eq("rst ad_o", ad_o, 32'd0);
        check_eq("rst wstrb", {28'd0, wstrb}, 32'd0);
        check_eq("rst proto", {31'd0, proto_err}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        run_txn("rd_word", BASE | 32'h10, 2'b11, 1'b0, 32'h0, 0, 32'hDEADBEEF, -1);
        run_txn("wr_b2", BASE | 32'h2, 2'b00, 1'b0, 32'h11223344, 0, 32'h0, -1);
        run_txn("wr_h1", BASE | 32'h3, 2'b01, 1'b0, 32'hA5A5_0000, 1, 32'h0, -1);
        run_txn("wr_h0", BASE | 32'h1, 2'b01, 1'b0, 32'h0000_5A5A, 2, 32'h0, -1);
        run_txn("ill_0110", BASE | 32'h2, 2'b01, 1'b0, 32'h0, 0, 32'h0, -1);
        run_txn("ill_1101", BASE | 32'h1, 2'b11, 1'b0, 32'h0, 0, 32'h0, -1);
        run_txn("miss", ~BASE, 2'b11, 1'b0, 32'h0, 0, 32'h0, -1);
        run_txn("bus_error", BASE, 2'b11, 1'b1, 32'h0, 0, 32'h0, -1);
        run_txn("timeout_rd", BASE | 32'h4, 2'b11, 1'b0, 32'h0, 100, 32'h0, -1);
        run_txn("timeout_wr", BASE | 32'h8, 2'b01, 1'b0, 32'hCAFEF00D, 100, 32'h0, -1);
        run_txn("ack_edge", BASE | 32'hC, 2'b11, 1'b0, 32'h0, TMO - 1, 32'h1234_5678, -1);
        run_txn("proto", BASE | 32'h20, 2'b11, 1'b0, 32'h0, 3, 32'h0BAD_F00D, 2);

        adrcyn = 1'b0; ad_i = BASE | 32'h24; tm1n = 1'b1; tm0n = 1'b1;
        @(posedge clk); @(negedge clk);
        adrcyn = 1'b1;
        check_eq("mid_rst req_before", {31'd0, loc_req}, 32'd1);
        rstn = 1'b0;
        #1;
        check_eq("mid_rst req", {31'd0, loc_req}, 32'd0);
        check_eq("mid_rst proto", {31'd0, proto_err}, 32'd0);
        check_eq("mid_rst rdyn", {31'd0, rdyn}, 32'd1);
        exp_proto = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                a = $urandom();
                if ((a & MASK) == BASE) a = a ^ 32'h0100_0000;
            end else begin
                a = BASE | ($urandom() & 32'h0000_FFFF);
            end
            tm = 2'($urandom_range(0, 3));
            r  = int'($urandom_range(0, 9));
            d  = (r == 0) ? TMO + int'($urandom_range(0, 3)) :
                 (r == 1) ? TMO - 1 : int'($urandom_range(0, 4));
            run_txn($sformatf("rnd%0d", i), a, tm, ($urandom_range(0, 9) == 0),
                    $urandom(), d, $urandom(), ($urandom_range(0, 6) == 0) ? 1 : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
